// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard, write-to-read bypass
// and a combinational RAW/WAW issue stall for the pipelined core.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [NRD-1:0]      iss_src_use,
    input  logic                iss_wb,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_stall,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wb_live;
    logic             waw;
    logic             iss_accept;

    assign wb_live = wb_en && (wb_addr != '0);

    // A port being written back this cycle sees the new data and is never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                if (wb_en && (wb_addr == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = wb_data;
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                    rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
                end
            end
        end
    end

    assign waw = iss_wb && (iss_rd != '0) && busy[iss_rd]
                 && !(wb_en && (wb_addr == iss_rd));

    assign iss_stall  = iss_valid && ((|(iss_src_use & rd_busy)) || waw);
    assign iss_accept = iss_valid && !iss_stall;

    // Clear first, then set, so an accepted issue wins over a same-address writeback.
    always_comb begin
        busy_nxt = busy;
        if (wb_live) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (iss_accept && iss_wb && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign busy_vec = busy;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a per-register scoreboard for the pipelined RV32I core. It replaces the single-issue 2-read/1-write register file. It adds:
- configurable width, depth and read-port count;
- same-cycle write-to-read bypass;
- busy tracking of in-flight destination registers;
- a combinational issue-stall output for RAW/WAW hazards.

It sits between decode (source/destination addresses) and writeback.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers (power of two, >=2).
NRD, 2, number of read ports.
AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
rd_addr  in  NRD*AW  read port addresses; port i = bits [i*AW +: AW].
rd_data  out  NRD*XLEN  read data, combinational; port i = bits [i*XLEN +: XLEN].
rd_busy  out  NRD  port i source is busy and not being written back this cycle.
iss_valid  in  1  decode presents an instruction for issue.
iss_src_use  in  NRD  bit i set = instruction consumes read port i.
iss_wb  in  1  instruction writes a destination register.
iss_rd  in  AW  destination register address.
iss_stall  out  1  issue blocked this cycle (combinational).
wb_en  in  1  writeback valid.
wb_addr  in  AW  writeback register address.
wb_data  in  XLEN  writeback data.
busy_vec  out  NREGS  current scoreboard bits (debug/observation).

Behaviour:
- Reset (rst=0, async):
  - all NREGS registers cleared to 0;
  - all busy bits cleared;
  - outputs follow combinationally: rd_data = 0 unless bypassed, rd_busy=0, iss_stall=0, busy_vec=0.
- Register 0: reads always 0, never busy; writes and busy-sets to address 0 ignored.
- Write: on rising clk with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
- Read, port i (combinational):
  - rd_addr==0 -> 0;
  - else if wb_en && wb_addr==rd_addr -> wb_data (bypass);
  - else -> reg[rd_addr].
- rd_busy[i] = busy[rd_addr_i] && !(wb_en && wb_addr==rd_addr_i) && rd_addr_i!=0.
- iss_stall = iss_valid && (any i with iss_src_use[i] && rd_busy[i], or WAW).
  - WAW = iss_wb && iss_rd!=0 && busy[iss_rd] && !(wb_en && wb_addr==iss_rd).
- Issue accepted: iss_valid && !iss_stall. If also iss_wb && iss_rd!=0, busy[iss_rd] <= 1 at clock edge.
- Writeback clear: wb_en && wb_addr!=0 -> busy[wb_addr] <= 0 at clock edge.
- Simultaneous accepted issue and writeback to the same address: busy ends 1 (set wins); register still takes wb_data.
- Writeback to a non-busy register is legal: data written, busy stays 0.
- Latency:
  - write visible on read ports in the same cycle via bypass, from the array the following cycle;
  - busy set visible the cycle after issue.
- Reset asserted mid-operation clears all state immediately; in-flight writebacks are lost.
- NRD=1 and NRD=4 must elaborate; no latches; all reg arrays reset.

Test Plan:
- Reset then read: rst=0 for 2 cycles, release. rd_addr={x2,x1} -> rd_data=0, busy_vec=0, iss_stall=0.
- Write/read: wb x1=7, next wb x2=12 (wb_en one cycle each). Then rd_addr={x2,x1} -> rd_data={12,7}, rd_busy=0.
- x0 protection: wb_en=1, wb_addr=0, wb_data=0xDEADBEEF; issue iss_rd=0. Then read x0 -> 0, busy_vec[0]=0.
- RAW stall and bypass:
  - issue iss_rd=x3, iss_wb=1 -> busy_vec[3]=1 next cycle;
  - issue with rd_addr0=x3, iss_src_use=01 -> iss_stall=1;
  - drive wb x3=19 the same cycle -> iss_stall=0, rd_data0=19, busy_vec[3]=0 after edge.
- WAW plus same-cycle set/clear:
  - x4 busy; issue iss_rd=x4 with no writeback -> iss_stall=1;
  - next cycle wb x4=5 together with issue iss_rd=x4 -> accepted, busy_vec[4] stays 1, reg x4=5.
- Async reset mid-run: x5 busy with value 9, assert rst=0 between clock edges. busy_vec=0 and read x5=0 without waiting for a clock edge.
